xled_ctrl: RTL and testbench

XLED_CTRL -- requirements
Module: xled_ctrl

---
 rtl/xled_ctrl.sv | 139 +++++++++++++
 tb/tb_xled_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xled_ctrl.sv
// Memory-mapped LED controller: four registers (CTRL, PATTERN, PERIOD, DUTY) driving
// a registered LED bus in static, blink, pwm or off mode.
module xled_ctrl #(
  parameter int N_LEDS = 8,
  parameter int CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic [N_LEDS-1:0] led
);

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_DUTY    = 2'd3;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_PWM    = 2'd2;

  logic [2:0]        ctrl_q,    ctrl_d;
  logic [N_LEDS-1:0] pattern_q, pattern_d;
  logic [CNT_W-1:0]  period_q,  period_d;
  logic [7:0]        duty_q,    duty_d;
  logic [CNT_W-1:0]  bcnt_q,    bcnt_d;
  logic              phase_q,   phase_d;
  logic [7:0]        pcnt_q,    pcnt_d;
  logic [N_LEDS-1:0] led_q,     led_d;

  logic             wr_en;
  logic             en;
  logic [1:0]       mode;
  logic             blink_act;
  logic             pwm_act;
  logic             cnt_clr;
  logic [CNT_W-1:0] bcnt_last;
  logic [31:0]      rd_val;
  logic             unused_data;

  assign unused_data = &{1'b0, data_in};

  assign wr_en     = sel & we;
  assign en        = ctrl_q[2];
  assign mode      = ctrl_q[1:0];
  assign blink_act = en && (mode == MODE_BLINK);
  assign pwm_act   = en && (mode == MODE_PWM);
  // Changing mode or period restarts every counter so the new setting starts cleanly.
  assign cnt_clr   = wr_en && ((addr == ADDR_CTRL) || (addr == ADDR_PERIOD));
  // PERIOD of 0 behaves like 1: last count is 0 either way.
  assign bcnt_last = (period_q == '0) ? '0 : (period_q - CNT_W'(1));

  always_comb begin
    ctrl_d    = ctrl_q;
    pattern_d = pattern_q;
    period_d  = period_q;
    duty_d    = duty_q;
    if (wr_en) begin
      case (addr)
        ADDR_CTRL:    ctrl_d    = data_in[2:0];
        ADDR_PATTERN: pattern_d = data_in[N_LEDS-1:0];
        ADDR_PERIOD:  period_d  = data_in[CNT_W-1:0];
        default:      duty_d    = data_in[7:0];
      endcase
    end
  end

  always_comb begin
    bcnt_d  = '0;
    phase_d = 1'b1;
    pcnt_d  = '0;
    if (!cnt_clr) begin
      if (blink_act) begin
        if (bcnt_q == bcnt_last) begin
          bcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          bcnt_d  = bcnt_q + CNT_W'(1);
          phase_d = phase_q;
        end
      end
      if (pwm_act) begin
        pcnt_d = pcnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    led_d = '0;
    if (en) begin
      case (mode)
        MODE_STATIC: led_d = pattern_q;
        MODE_BLINK:  led_d = phase_q ? pattern_q : '0;
        MODE_PWM:    led_d = (pcnt_q < duty_q) ? pattern_q : '0;
        default:     led_d = '0;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_CTRL:    rd_val[2:0]        = ctrl_q;
      ADDR_PATTERN: rd_val[N_LEDS-1:0] = pattern_q;
      ADDR_PERIOD:  rd_val[CNT_W-1:0]  = period_q;
      default:      rd_val[7:0]        = duty_q;
    endcase
  end

  assign data_out = (sel && !we) ? rd_val : 32'd0;
  assign led      = led_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= '0;
      pattern_q <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      bcnt_q    <= '0;
      phase_q   <= 1'b1;
      pcnt_q    <= '0;
      led_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      pattern_q <= pattern_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      pcnt_q    <= pcnt_d;
      led_q     <= led_d;
    end
  end

endmodule

// File: tb/tb_xled_ctrl.sv
// Scenario bench for xled_ctrl: expected LED and read values are queued as stimulus
// is applied and popped as the DUT produces each cycle's output.
module tb_xled_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic [7:0]  led;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  xled_ctrl #(.N_LEDS(8), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .led(led)
  );

  always #5 clk = ~clk;

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0; data_in = 32'd0;
  endtask

  task automatic rd_drive(input logic [1:0] a);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (led !== 8'h00) begin bad++; $display("FAIL reset_led got=%h want=00", led); end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_drive(2'(i));
      exp_v = exp_q.pop_front();
      total++;
      if (data_out !== exp_v) begin bad++; $display("FAIL reset_reg%0d got=%h want=%h", i, data_out, exp_v); end
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (led !== 8'h00) begin bad++; $display("FAIL reset_release_led got=%h want=00", led); end
  endtask

  task automatic test_regs();
    wr_reg(2'd0, 32'hFFFF_FFF9); exp_q.push_back(32'h0000_0001);
    wr_reg(2'd1, 32'hDEAD_BE5A); exp_q.push_back(32'h0000_005A);
    wr_reg(2'd2, 32'hAB12_3456); exp_q.push_back(32'h0012_3456);
    wr_reg(2'd3, 32'h0000_1234); exp_q.push_back(32'h0000_0034);
    for (int i = 0; i < 4; i++) begin
      rd_drive(2'(i));
      exp_v = exp_q.pop_front();
      total++;
      if (data_out !== exp_v) begin bad++; $display("FAIL regs_width%0d got=%h want=%h", i, data_out, exp_v); end
    end
    @(negedge clk);
    sel = 1'b0; addr = 2'd1;
    #1;
    total++;
    if (data_out !== 32'd0) begin bad++; $display("FAIL read_unselected got=%h want=0", data_out); end
    sel = 1'b1; we = 1'b1; data_in = 32'h0000_005A;
    #1;
    total++;
    if (data_out !== 32'd0) begin bad++; $display("FAIL read_during_write got=%h want=0", data_out); end
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic test_static();
    wr_reg(2'd1, 32'h0000_00A5);
    wr_reg(2'd0, 32'h0000_0004);
    total++;
    if (led !== 8'h00) begin bad++; $display("FAIL static_early got=%h want=00", led); end
    @(posedge clk); #1;
    total++;
    if (led !== 8'hA5) begin bad++; $display("FAIL static_led got=%h want=a5", led); end
    exp_q.push_back(32'h0000_00A5);
    rd_drive(2'd1);
    exp_v = exp_q.pop_front();
    total++;
    if (data_out !== exp_v) begin bad++; $display("FAIL static_read got=%h want=%h", data_out, exp_v); end
    sel = 1'b0;
    wr_reg(2'd0, 32'h0000_0007);
    @(posedge clk); #1;
    total++;
    if (led !== 8'h00) begin bad++; $display("FAIL off_mode got=%h want=00", led); end
  endtask

  task automatic test_blink();
    wr_reg(2'd1, 32'h0000_00FF);
    wr_reg(2'd2, 32'd3);
    wr_reg(2'd0, 32'h0000_0005);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) exp_q.push_back(32'h0000_00FF);
      for (int i = 0; i < 3; i++) exp_q.push_back(32'h0000_0000);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      total++;
      if ({24'd0, led} !== exp_v) begin bad++; $display("FAIL blink3 cyc%0d got=%h want=%h", i, led, exp_v); end
    end
    wr_reg(2'd2, 32'd0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h0000_00FF);
      exp_q.push_back(32'h0000_0000);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      total++;
      if ({24'd0, led} !== exp_v) begin bad++; $display("FAIL blink0 cyc%0d got=%h want=%h", i, led, exp_v); end
    end
  endtask

  task automatic test_pattern_no_disturb();
    wr_reg(2'd2, 32'd3);
    @(posedge clk); #1;
    total++;
    if (led !== 8'hFF) begin bad++; $display("FAIL nodist_e1 got=%h want=ff", led); end
    wr_reg(2'd1, 32'h0000_003C);
    total++;
    if (led !== 8'hFF) begin bad++; $display("FAIL nodist_e2 got=%h want=ff", led); end
    exp_q.push_back(32'h3C);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h00);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h3C);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      total++;
      if ({24'd0, led} !== exp_v) begin bad++; $display("FAIL nodist cyc%0d got=%h want=%h", i, led, exp_v); end
    end
  endtask

  task automatic test_period_write_wins();
    wr_reg(2'd1, 32'h0000_00FF);
    wr_reg(2'd2, 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (led !== 8'hFF) begin bad++; $display("FAIL pw_pre cyc%0d got=%h want=ff", i, led); end
    end
    wr_reg(2'd2, 32'd2);
    total++;
    if (led !== 8'hFF) begin bad++; $display("FAIL pw_edge got=%h want=ff", led); end
    exp_q.push_back(32'hFF); exp_q.push_back(32'hFF);
    exp_q.push_back(32'h00); exp_q.push_back(32'h00);
    exp_q.push_back(32'hFF); exp_q.push_back(32'hFF);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      total++;
      if ({24'd0, led} !== exp_v) begin bad++; $display("FAIL pw_post cyc%0d got=%h want=%h", i, led, exp_v); end
    end
    exp_q.push_back(32'd2);
    rd_drive(2'd2);
    exp_v = exp_q.pop_front();
    total++;
    if (data_out !== exp_v) begin bad++; $display("FAIL pw_read got=%h want=%h", data_out, exp_v); end
    sel = 1'b0;
  endtask

  task automatic test_pwm();
    int on_cnt;
    int off_cnt;
    on_cnt = 0; off_cnt = 0;
    wr_reg(2'd1, 32'h0000_000F);
    wr_reg(2'd3, 32'd64);
    wr_reg(2'd0, 32'h0000_0006);
    for (int i = 0; i < 256; i++) exp_q.push_back((i < 64) ? 32'h0F : 32'h00);
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      if (led === 8'h0F) on_cnt++;
      else if (led === 8'h00) off_cnt++;
      total++;
      if ({24'd0, led} !== exp_v) begin bad++; $display("FAIL pwm64 cyc%0d got=%h want=%h", i, led, exp_v); end
    end
    total++;
    if (on_cnt != 64) begin bad++; $display("FAIL pwm64_on got=%0d want=64", on_cnt); end
    total++;
    if (off_cnt != 192) begin bad++; $display("FAIL pwm64_off got=%0d want=192", off_cnt); end
  endtask

  task automatic test_duty_edges();
    int on_cnt;
    wr_reg(2'd3, 32'd0);
    for (int i = 0; i < 260; i++) exp_q.push_back(32'h00);
    for (int i = 0; i < 260; i++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      total++;
      if ({24'd0, led} !== exp_v) begin bad++; $display("FAIL duty0 cyc%0d got=%h want=%h", i, led, exp_v); end
    end
    on_cnt = 0;
    wr_reg(2'd3, 32'd255);
    wr_reg(2'd0, 32'h0000_0006);
    for (int i = 0; i < 256; i++) exp_q.push_back((i < 255) ? 32'h0F : 32'h00);
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      if (led === 8'h0F) on_cnt++;
      total++;
      if ({24'd0, led} !== exp_v) begin bad++; $display("FAIL duty255 cyc%0d got=%h want=%h", i, led, exp_v); end
    end
    total++;
    if (on_cnt != 255) begin bad++; $display("FAIL duty255_on got=%0d want=255", on_cnt); end
  endtask

  task automatic test_reset_mid_pwm();
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (led !== 8'h00) begin bad++; $display("FAIL rst_mid_led got=%h want=00", led); end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_drive(2'(i));
      exp_v = exp_q.pop_front();
      total++;
      if (data_out !== exp_v) begin bad++; $display("FAIL rst_mid_reg%0d got=%h want=%h", i, data_out, exp_v); end
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sel = 1'b0; we = 1'b1; addr = 2'd0; data_in = 32'h0000_0004;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (led !== 8'h00) begin bad++; $display("FAIL idle_after_rst cyc%0d got=%h want=00", i, led); end
    end
    we = 1'b0; data_in = 32'd0;
    exp_q.push_back(32'd0);
    rd_drive(2'd0);
    exp_v = exp_q.pop_front();
    total++;
    if (data_out !== exp_v) begin bad++; $display("FAIL sel0_ctrl got=%h want=%h", data_out, exp_v); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_static();
    test_blink();
    test_pattern_no_disturb();
    test_period_write_wins();
    test_pwm();
    test_duty_edges();
    test_reset_mid_pwm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
